// File: rtl/lut_layer_pkg.sv
`default_nettype none
// ============================================================================
// lut_layer_pkg : shared FSM state type and truth-table address helpers
// Revision      : 1.0
// ============================================================================
package lut_layer_pkg;

  // Wide enough for any practical neuron-count / fan-in combination.
  localparam int TBL_AW = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [TBL_AW-1:0] tbl_addr_t;

  function automatic tbl_addr_t tbl_base(input int neuron, input int fanin);
    return tbl_addr_t'(neuron) << fanin;
  endfunction

  function automatic tbl_addr_t pack_addr(input int neuron, input int idx, input int fanin);
    return tbl_base(neuron, fanin) | tbl_addr_t'(idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lut_table_mem.sv
`default_nettype none
// ============================================================================
// lut_table_mem : shared 1-bit truth-table store, registered read port,
//                 write port present only when LUT_CFG_EN is defined
// Revision      : 1.0
// ============================================================================
module lut_table_mem
  import lut_layer_pkg::*;
#(
  parameter int               DEPTH = 4096,
  parameter logic [DEPTH-1:0] INIT  = '0
) (
  input  logic      clk,
  input  logic      rst,
  input  tbl_addr_t rd_addr,
  output logic      rd_data
`ifdef LUT_CFG_EN
  ,
  input  logic      wr_en,
  input  tbl_addr_t wr_addr,
  input  logic      wr_data
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic rd_ok;
  assign rd_ok = (rd_addr < tbl_addr_t'(DEPTH));

`ifdef LUT_CFG_EN
  logic [DEPTH-1:0] mem;
  logic             wr_ok;
  assign wr_ok = (wr_addr < tbl_addr_t'(DEPTH));

  // Reset reloads the boot image, so configuration writes do not survive rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem     <= INIT;
      rd_data <= 1'b0;
    end else begin
      if (wr_en && wr_ok) mem[wr_addr[AW-1:0]] <= wr_data;
      rd_data <= rd_ok ? mem[rd_addr[AW-1:0]] : 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) rd_data <= 1'b0;
    else     rd_data <= rd_ok ? INIT[rd_addr[AW-1:0]] : 1'b0;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/lut_layer_sched.sv
`default_nettype none
// ============================================================================
// lut_layer_sched : time-multiplexed LogicNets layer, one LUT neuron per cycle
//                   from a shared table; LUT_CFG_EN adds a runtime write port
// Revision        : 1.0
// ============================================================================
module lut_layer_sched
  import lut_layer_pkg::*;
#(
  parameter int IN_BITS   = 64,
  parameter int N_NEURONS = 16,
  parameter int FANIN     = 8,
  parameter logic [N_NEURONS*FANIN*$clog2(IN_BITS)-1:0] CONN_INIT  = '0,
  parameter logic [N_NEURONS*(2**FANIN)-1:0]            TABLE_INIT = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_BITS-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_NEURONS-1:0] out_data,
`ifdef LUT_CFG_EN
  input  logic                 cfg_we,
  output logic                 cfg_ready,
  input  logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)+FANIN-1:0] cfg_addr,
  input  logic                 cfg_data,
`endif
  output logic                 busy
);

  localparam int IW    = $clog2(IN_BITS);
  localparam int NW    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int CW    = $clog2(N_NEURONS + 1);
  localparam int DEPTH = N_NEURONS * (2**FANIN);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_NEURONS - 1);
  localparam logic [NW-1:0] LAST_N   = NW'(N_NEURONS - 1);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [IN_BITS-1:0] vec_q;
  logic [FANIN-1:0]  gather;
  logic [IW-1:0]     sel;
  logic              a_v, b_v;
  logic [NW-1:0]     a_n, b_n;
  logic [FANIN-1:0]  a_idx;
  tbl_addr_t         rd_addr;
  logic              rd_data;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = RUN;
      end
      RUN:     if (cnt == LAST_CNT) state_nx = DRAIN;
      DRAIN:   if (b_v && (b_n == LAST_N)) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage A: gather the neuron's fan-in bits; conn entry 0 lands in the LSB.
  always_comb begin
    gather = '0;
    sel    = '0;
    for (int j = 0; j < FANIN; j++) begin
      sel       = CONN_INIT[(int'(cnt[NW-1:0]) * FANIN + j) * IW +: IW];
      gather[j] = (int'(sel) < IN_BITS) ? vec_q[sel] : vec_q[0];
    end
  end

  assign rd_addr = pack_addr(int'(a_n), int'(a_idx), FANIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      vec_q    <= '0;
      a_v      <= 1'b0;
      a_n      <= '0;
      a_idx    <= '0;
      b_v      <= 1'b0;
      b_n      <= '0;
      out_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        vec_q <= in_data;
        cnt   <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
      end
      a_v   <= (state == RUN);
      a_n   <= cnt[NW-1:0];
      a_idx <= gather;
      // b_* tags line up with the table's registered read data.
      b_v   <= a_v;
      b_n   <= a_n;
      if (b_v) out_data[b_n] <= rd_data;
    end
  end

`ifdef LUT_CFG_EN
  logic cfg_ready_q;

  always_ff @(posedge clk) begin
    if (rst) cfg_ready_q <= 1'b0;
    else     cfg_ready_q <= (state_nx == IDLE);
  end

  assign cfg_ready = cfg_ready_q;

  lut_table_mem #(
    .DEPTH (DEPTH),
    .INIT  (TABLE_INIT)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (cfg_we && cfg_ready_q),
    .wr_addr (tbl_addr_t'(cfg_addr)),
    .wr_data (cfg_data)
  );
`else
  lut_table_mem #(
    .DEPTH (DEPTH),
    .INIT  (TABLE_INIT)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_lut_layer_sched.sv
`default_nettype none
// ============================================================================
// tb_lut_layer_sched : randomized self-checking bench with a per-neuron table model
// Revision           : 1.0
// ============================================================================
module tb_lut_layer_sched;

  localparam int IN_BITS = 64;
  localparam int N       = 16;
  localparam int FANIN   = 8;
  localparam int IW      = 6;
  localparam int NW      = 4;
  localparam int TD      = 1 << FANIN;
  localparam int CONN_W  = N * FANIN * IW;
  localparam int TBL_W   = N * TD;

  function automatic logic [CONN_W-1:0] make_conn();
    logic [CONN_W-1:0] c;
    logic [31:0]       s;
    c = '0;
    s = 32'h1234_5678;
    for (int n = 0; n < N; n++) begin
      for (int j = 0; j < FANIN; j++) begin
        s = s * 32'd1664525 + 32'd1013904223;
        c[(n*FANIN+j)*IW +: IW] = (n == 0) ? IW'(j) : s[31:26];
      end
    end
    return c;
  endfunction

  function automatic logic [TBL_W-1:0] make_tbl();
    logic [TBL_W-1:0] t;
    logic [31:0]      s;
    t = '0;
    s = 32'hCAFE_0001;
    for (int n = 0; n < N; n++) begin
      for (int a = 0; a < TD; a++) begin
        s = s * 32'd1664525 + 32'd1013904223;
        if (n == 0)                t[n*TD+a] = (a == TD - 1);
        else if (n == 3 && a == 0) t[n*TD+a] = 1'b0;
        else                       t[n*TD+a] = s[31];
      end
    end
    return t;
  endfunction

  localparam logic [CONN_W-1:0] CONN  = make_conn();
  localparam logic [TBL_W-1:0]  TABLE = make_tbl();

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [IN_BITS-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       out_data;
  logic               busy;
`ifdef LUT_CFG_EN
  logic               cfg_we;
  logic               cfg_ready;
  logic [NW+FANIN-1:0] cfg_addr;
  logic               cfg_data;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic tbl_m [TBL_W];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lut_layer_sched #(
    .IN_BITS    (IN_BITS),
    .N_NEURONS  (N),
    .FANIN      (FANIN),
    .CONN_INIT  (CONN),
    .TABLE_INIT (TABLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef LUT_CFG_EN
    .cfg_we    (cfg_we),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
`endif
    .busy      (busy)
  );

  // Reference: each neuron looks up its table with the gathered fan-in bits.
  function automatic logic [N-1:0] model(input logic [IN_BITS-1:0] v);
    logic [N-1:0]  r;
    logic [IW-1:0] k;
    int            a;
    r = '0;
    for (int n = 0; n < N; n++) begin
      a = 0;
      for (int j = 0; j < FANIN; j++) begin
        k = CONN[(n*FANIN+j)*IW +: IW];
        a = a + (int'(v[k]) << j);
      end
      r[n] = tbl_m[n*TD + a];
    end
    return r;
  endfunction

  function automatic logic [IN_BITS-1:0] rand_vec();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_table_reset();
    for (int i = 0; i < TBL_W; i++) tbl_m[i] = TABLE[i];
  endtask

  // Offer a vector, wait for acceptance, then count edges until out_valid.
  task automatic start_and_wait(input logic [IN_BITS-1:0] v, output int lat, output bit ok);
    bit acc;
    acc      = 1'b0;
    ok       = 1'b0;
    lat      = 0;
    in_data  = v;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (in_ready) acc = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) return;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    ok = out_valid;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef LUT_CFG_EN
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = 1'b0;
`endif
    model_table_reset();
    tick();
    tick();
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0)    begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef LUT_CFG_EN
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL reset_cfg_ready got=%b exp=0", cfg_ready); end
`endif
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle in_ready=%b busy=%b exp in_ready=1 busy=0", in_ready, busy);
    end
  endtask

  task automatic test_and_neuron();
    logic [IN_BITS-1:0] v;
    int lat;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? 64'hFF : 64'hFE;
      start_and_wait(v, lat, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL and_timeout vec=%h got no out_valid exp out_valid=1", v);
      end else begin
        if (out_data[0] !== (k == 0)) begin
          failures++; $display("FAIL and_neuron0 vec=%h got=%b exp=%b", v, out_data[0], (k == 0));
        end
        checks++;
        if (out_data !== model(v)) begin
          failures++; $display("FAIL and_full vec=%h got=%h exp=%h", v, out_data, model(v));
        end
      end
      release_out();
    end
  endtask

  task automatic test_latency_stall();
    logic [IN_BITS-1:0] v;
    logic [N-1:0]       held;
    int lat;
    bit ok;
    v = rand_vec();
    start_and_wait(v, lat, ok);
    checks++;
    if (!ok || lat != N + 2) begin
      failures++; $display("FAIL latency got=%0d ok=%b exp=%0d", lat, ok, N + 2);
    end
    checks++;
    if (out_data !== model(v)) begin
      failures++; $display("FAIL latency_data got=%h exp=%h", out_data, model(v));
    end
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got valid=%b data=%h in_ready=%b exp valid=1 data=%h in_ready=0",
                 i, out_valid, out_data, in_ready, held);
      end
    end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL after_release got valid=%b in_ready=%b exp valid=0 in_ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_q[$];
    int acc_t[$];
    int sent, got;
    bit acc, hs;
    sent = 0;
    got  = 0;
    out_ready = 1'b1;
    in_data   = rand_vec();
    in_valid  = 1'b1;
    for (int c = 0; c < 300 && got < 4; c++) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (acc) exp_q.push_back(model(in_data));
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_spurious got=%h exp=no output", out_data);
        end else if (out_data !== exp_q[0]) begin
          failures++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", got, out_data, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      tick();
      if (acc) begin
        acc_t.push_back(cyc);
        sent++;
        if (sent < 4) in_data = rand_vec();
        else          in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != 4) begin
      failures++; $display("FAIL b2b_count got=%0d exp=4", got);
    end
    for (int i = 1; i < acc_t.size(); i++) begin
      checks++;
      if (acc_t[i] - acc_t[i-1] != N + 4) begin
        failures++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=%0d", i, acc_t[i] - acc_t[i-1], N + 4);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [IN_BITS-1:0] v;
    int lat;
    bit ok;
    in_data  = rand_vec();
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    model_table_reset();
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      failures++;
      $display("FAIL midrun_reset got valid=%b in_ready=%b data=%h exp valid=0 in_ready=1 data=0",
               out_valid, in_ready, out_data);
    end
    tick();
    v = rand_vec();
    start_and_wait(v, lat, ok);
    checks++;
    if (!ok || lat != N + 2 || out_data !== model(v)) begin
      failures++;
      $display("FAIL midrun_recover got lat=%0d data=%h exp lat=%0d data=%h", lat, out_data, N + 2, model(v));
    end
    release_out();
  endtask

`ifdef LUT_CFG_EN
  task automatic test_cfg();
    int lat;
    bit ok;
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++; $display("FAIL cfg_ready_idle got=%b exp=1", cfg_ready);
    end
    // A write offered while busy must be dropped.
    in_data  = '0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cfg_addr = {NW'(3), FANIN'(0)};
    cfg_data = 1'b1;
    cfg_we   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cfg_ready !== 1'b0) begin
        failures++; $display("FAIL cfg_ready_busy got=%b exp=0", cfg_ready);
      end
      tick();
    end
    cfg_we = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    release_out();
    start_and_wait('0, lat, ok);
    checks++;
    if (!ok || out_data[3] !== 1'b0) begin
      failures++; $display("FAIL cfg_busy_ignored got=%b ok=%b exp=0", out_data[3], ok);
    end
    release_out();
    // Write and accept in the same idle cycle: the run sees the new bit.
    tick();
    cfg_we   = 1'b1;
    in_data  = '0;
    in_valid = 1'b1;
    checks++;
    if (cfg_ready !== 1'b1 || in_ready !== 1'b1) begin
      failures++; $display("FAIL cfg_same_cycle_ready got cfg_ready=%b in_ready=%b exp 1 1", cfg_ready, in_ready);
    end
    tick();
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    tbl_m[3*TD + 0] = 1'b1;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    checks++;
    if (!out_valid || out_data[3] !== 1'b1 || out_data !== model('0)) begin
      failures++; $display("FAIL cfg_write got=%h exp=%h (bit3=1)", out_data, model('0));
    end
    release_out();
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] exp_q[$];
    int sent, got;
    bit hs;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 60000 && got < 1000; c++) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data   = rand_vec();
      out_ready = ($urandom_range(0, 2) != 0);
      hs = out_valid && out_ready;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
        sent++;
      end
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_spurious got=%h exp=no output", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin
            failures++; $display("FAIL rand_data idx=%0d got=%h exp=%h", got, out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        got++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != 1000) begin
      failures++; $display("FAIL rand_count got=%0d exp=1000", got);
    end
  endtask

  initial begin
    test_reset();
    test_and_neuron();
    test_latency_stall();
    test_back_to_back();
    test_reset_mid_run();
`ifdef LUT_CFG_EN
    test_cfg();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
